// File: rtl/cond_exec_ctrl.sv
// rtl/cond_exec_ctrl.sv - EXE-stage condition evaluation, NZCV status register and branch squash control
module cond_exec_ctrl #(
  parameter int unsigned FLUSH_LEN    = 2,
  parameter logic [3:0]  STATUS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       exe_valid,
  input  logic [3:0] exe_cond,
  input  logic       exe_s,
  input  logic       exe_branch,
  input  logic [3:0] alu_status,
  output logic [3:0] status,
  output logic       exe_commit,
  output logic       branch_taken,
  output logic       squash_active
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] status_q, status_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic kill;
  logic commit;

  assign flag_n = status_q[3];
  assign flag_z = status_q[2];
  assign flag_c = status_q[1];
  assign flag_v = status_q[0];

  // Condition field decode; uses the registered flags only, never the live ALU flags
  always_comb begin
    cond_pass = 1'b0;
    case (exe_cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign kill   = (state_q == SQUASH);
  assign commit = exe_valid & cond_pass & ~kill & ~freeze;

  // Flag update: only a committed S-bit instruction writes; commit already excludes freeze
  always_comb begin
    status_d = status_q;
    if (commit && exe_s) begin
      status_d = alu_status;
    end
  end

  // Squash FSM next state: a taken branch arms the counter, each valid EXE slot consumes one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      case (state_q)
        RUN: begin
          if (commit && exe_branch) begin
            state_d = SQUASH;
            cnt_d   = 4'(FLUSH_LEN);
          end
        end
        SQUASH: begin
          if (exe_valid) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers; reset wins over freeze and over a same-cycle flag write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      status_q <= STATUS_RESET;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign status        = status_q;
  assign exe_commit    = commit;
  assign branch_taken  = commit & exe_branch;
  assign squash_active = (state_q == SQUASH);

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb/tb_cond_exec_ctrl.sv - directed and randomized checks of cond_exec_ctrl against a behavioural model
module tb_cond_exec_ctrl;

  localparam int FLUSH = 2;

  logic       clk = 1'b0;
  logic       rst, freeze, exe_valid, exe_s, exe_branch;
  logic [3:0] exe_cond, alu_status;
  logic [3:0] status;
  logic       exe_commit, branch_taken, squash_active;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  logic [3:0] m_status;
  int         m_left;

  // values sampled before the most recent edge
  logic       s_commit, s_br, s_sq;
  logic [3:0] s_status;

  always #5 clk = ~clk;

  cond_exec_ctrl #(.FLUSH_LEN(FLUSH), .STATUS_RESET(4'b0000)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_valid(exe_valid),
    .exe_cond(exe_cond), .exe_s(exe_s), .exe_branch(exe_branch),
    .alu_status(alu_status), .status(status), .exe_commit(exe_commit),
    .branch_taken(branch_taken), .squash_active(squash_active)
  );

  // Condition meaning from the flag names: even codes test a predicate, odd codes its inverse
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] st);
    bit n, z, cy, v, base;
    n = st[3]; z = st[2]; cy = st[1]; v = st[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check outputs against model before the edge, then advance model
  task automatic apply(input logic r, input logic frz, input logic v, input logic [3:0] c,
                       input logic s, input logic br, input logic [3:0] alu);
    logic pc, pb;
    @(negedge clk);
    rst = r; freeze = frz; exe_valid = v; exe_cond = c;
    exe_s = s; exe_branch = br; alu_status = alu;
    #1;
    pc = v && model_pass(c, m_status) && (m_left == 0) && !frz;
    pb = pc && br;
    chk("commit", {3'b0, exe_commit}, {3'b0, pc});
    chk("branch_taken", {3'b0, branch_taken}, {3'b0, pb});
    chk("squash_active", {3'b0, squash_active}, {3'b0, m_left > 0});
    chk("status", status, m_status);
    s_commit = exe_commit; s_br = branch_taken; s_sq = squash_active; s_status = status;
    @(posedge clk);
    if (r) begin
      m_status = 4'b0000;
      m_left   = 0;
    end else if (!frz) begin
      if (pc && s) m_status = alu;
      if (m_left > 0) begin
        if (v) m_left--;
      end else if (pb) begin
        m_left = FLUSH;
      end
    end
  endtask

  initial begin
    m_status = 4'b0000; m_left = 0;
    rst = 1'b0; freeze = 1'b0; exe_valid = 1'b0; exe_cond = 4'd0;
    exe_s = 1'b0; exe_branch = 1'b0; alu_status = 4'd0;

    // 1 reset
    apply(1, 0, 0, 4'hE, 0, 0, 4'h0);
    apply(0, 0, 0, 4'hE, 0, 0, 4'h0);
    chk("t1_status", s_status, 4'b0000);
    chk("t1_squash", {3'b0, s_sq}, 4'd0);
    chk("t1_commit", {3'b0, s_commit}, 4'd0);

    // 2 EQ against Z, then back-to-back re-evaluation
    apply(0, 0, 1, 4'hE, 1, 0, 4'b0100);
    apply(0, 0, 1, 4'h0, 1, 0, 4'b1000);
    chk("t2_eq_commit", {3'b0, s_commit}, 4'd1);
    apply(0, 0, 1, 4'h0, 0, 0, 4'b0000);
    chk("t2_status", s_status, 4'b1000);
    chk("t2_eq_fail", {3'b0, s_commit}, 4'd0);

    // 3 failed condition writes nothing; NV never commits
    apply(0, 0, 1, 4'hE, 1, 0, 4'b0100);
    apply(0, 0, 1, 4'h1, 1, 0, 4'b0011);
    chk("t3_ne_fail", {3'b0, s_commit}, 4'd0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 1, 4'hF, 1, 0, 4'(i * 5));
      chk("t3_nv", {3'b0, s_commit}, 4'd0);
    end
    chk("t3_status", s_status, 4'b0100);

    // 4 branch squash with an interleaved bubble
    apply(0, 0, 1, 4'hE, 0, 1, 4'h0);
    chk("t4_pulse", {3'b0, s_br}, 4'd1);
    apply(0, 0, 1, 4'hE, 1, 0, 4'b1111);
    chk("t4_kill1", {3'b0, s_commit}, 4'd0);
    chk("t4_sq1", {3'b0, s_sq}, 4'd1);
    apply(0, 0, 0, 4'hE, 1, 0, 4'b1111);
    apply(0, 0, 1, 4'hE, 1, 1, 4'b1111);
    chk("t4_kill2", {3'b0, s_commit}, 4'd0);
    chk("t4_nopulse", {3'b0, s_br}, 4'd0);
    apply(0, 0, 1, 4'hE, 1, 0, 4'b0010);
    chk("t4_commit3", {3'b0, s_commit}, 4'd1);
    chk("t4_sq_off", {3'b0, s_sq}, 4'd0);
    chk("t4_status", s_status, 4'b0100);

    // 5 frozen branch, then frozen flag setter
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 4'hE, 0, 1, 4'h0);
      chk("t5_frz_br", {3'b0, s_br}, 4'd0);
    end
    apply(0, 0, 1, 4'hE, 0, 1, 4'h0);
    chk("t5_pulse", {3'b0, s_br}, 4'd1);
    apply(0, 0, 1, 4'hE, 0, 0, 4'h0);
    chk("t5_sq", {3'b0, s_sq}, 4'd1);
    apply(0, 0, 1, 4'hE, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 4'hE, 1, 0, 4'b0010);
    apply(0, 0, 1, 4'hE, 1, 0, 4'b0010);
    apply(0, 0, 0, 4'hE, 0, 0, 4'h0);
    chk("t5_status", s_status, 4'b0010);

    // 6 reset aborts squash; GT/LE boundary cases
    apply(0, 0, 1, 4'hE, 0, 1, 4'h0);
    apply(1, 0, 0, 4'hE, 0, 0, 4'h0);
    apply(0, 0, 1, 4'hE, 1, 0, 4'b1000);
    chk("t6_after_rst", {3'b0, s_commit}, 4'd1);
    apply(0, 0, 1, 4'hD, 1, 0, 4'b0110);
    chk("t6_le", {3'b0, s_commit}, 4'd1);
    apply(0, 0, 1, 4'h8, 0, 0, 4'h0);
    chk("t6_hi", {3'b0, s_commit}, 4'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
